cordic_arbiter: RTL

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/cordic_arbiter.sv
// Two-channel round-robin front end that shares one CORDIC core: it latches a
// winner's operands, starts the core, waits for ready (or times out) and holds the response.
module cordic_arbiter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_ch0,
  input  logic         req_ch1,
  input  logic         op_ch0,
  input  logic         op_ch1,
  input  logic [W-1:0] angle_ch0,
  input  logic [W-1:0] angle_ch1,
  output logic         grant_ch0,
  output logic         grant_ch1,
  output logic         valid_ch0,
  output logic         valid_ch1,
  input  logic         rack_ch0,
  input  logic         rack_ch1,
  output logic [W-1:0] result_out,
  output logic         err_out,
  output logic         beg_FSM_CORDIC,
  output logic         operation,
  output logic [W-1:0] data_in,
  input  logic         ready_CORDIC,
  input  logic [W-1:0] data_cordic,
  output logic         ACK_FSM_CORDIC
);

  typedef enum logic [2:0] {IDLE, START, WAIT, ACK, RESP} state_t;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  state_t         state_q;
  logic           sel_q;
  logic           last_q;
  logic [15:0]    cnt_q;
  logic [W-1:0]   result_q;
  logic           err_q;
  logic           op_q;
  logic [W-1:0]   data_q;
  logic           win_d;
  logic           rack_own;

  // On a tie the channel not served last wins; a lone requester always wins.
  always_comb begin
    win_d = req_ch1;
    if (req_ch0 && req_ch1) win_d = ~last_q;
  end

  assign rack_own = sel_q ? rack_ch1 : rack_ch0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      op_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_ch0 || req_ch1) begin
            sel_q   <= win_d;
            op_q    <= win_d ? op_ch1 : op_ch0;
            data_q  <= win_d ? angle_ch1 : angle_ch0;
            state_q <= START;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          // A core completion in the timeout cycle still counts as success.
          if (ready_CORDIC) begin
            result_q <= data_cordic;
            err_q    <= 1'b0;
            state_q  <= ACK;
          end else if (cnt_q == TO_CNT) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state_q  <= RESP;
          end
        end
        ACK: state_q <= RESP;
        RESP: begin
          if (rack_own) begin
            last_q  <= sel_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_ch0      = (state_q == START) && !sel_q;
  assign grant_ch1      = (state_q == START) &&  sel_q;
  assign beg_FSM_CORDIC = (state_q == START);
  assign ACK_FSM_CORDIC = (state_q == ACK);
  assign valid_ch0      = (state_q == RESP) && !sel_q;
  assign valid_ch1      = (state_q == RESP) &&  sel_q;
  assign result_out     = result_q;
  assign err_out        = err_q;
  assign operation      = op_q;
  assign data_in        = data_q;

endmodule
